qos_dequeue_scheduler: RTL

//  Dequeue scheduler for the two-class QoS queue. Source-IP matching steers packets

---
 rtl/qos_dequeue_scheduler.sv | 73 +++++++
 1 files changed

// File: rtl/qos_dequeue_scheduler.sv
// qos_dequeue_scheduler: whole-packet weighted strict-priority dequeue of hi/lo FIFOs with lo anti-starvation credit
module qos_dequeue_scheduler #(
  parameter int CNT_W    = 16,
  parameter int WEIGHT_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sched_en,
  input  logic                cfg_wen,
  input  logic [WEIGHT_W-1:0] cfg_hi_weight,
  input  logic                hi_empty,
  input  logic                hi_eop,
  input  logic                lo_empty,
  input  logic                lo_eop,
  input  logic                out_rdy,
  output logic                hi_rd_en,
  output logic                lo_rd_en,
  output logic                out_wr,
  output logic                out_sel,
  output logic [CNT_W-1:0]    hi_pkt_cnt,
  output logic [CNT_W-1:0]    lo_pkt_cnt
);
  typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO} state_t;
  state_t state, state_nxt;
  logic [WEIGHT_W-1:0] weight, burst_cnt, burst_nxt;
  logic lo_starved;
  // pops follow the active class; IDLE decides the next packet class and burst credit
  always_comb begin
    state_nxt  = state;
    burst_nxt  = burst_cnt;
    hi_rd_en   = (state == SEND_HI) && !hi_empty && out_rdy;
    lo_rd_en   = (state == SEND_LO) && !lo_empty && out_rdy;
    out_wr     = hi_rd_en | lo_rd_en;
    lo_starved = (weight != '0) && (burst_cnt >= weight) && !lo_empty;
    case (state)
      IDLE: begin
        if (sched_en) begin
          if (lo_starved) begin
            state_nxt = SEND_LO;
            burst_nxt = '0;
          end else if (!hi_empty) begin
            state_nxt = SEND_HI;
            burst_nxt = lo_empty ? '0 : (&burst_cnt ? burst_cnt : burst_cnt + 1'b1);
          end else if (!lo_empty) begin
            state_nxt = SEND_LO;
            burst_nxt = '0;
          end
        end
      end
      SEND_HI: state_nxt = (hi_rd_en && hi_eop) ? IDLE : SEND_HI;
      SEND_LO: state_nxt = (lo_rd_en && lo_eop) ? IDLE : SEND_LO;
      default: state_nxt = IDLE;
    endcase
  end
  // state, config, burst credit, output select and packet counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      weight     <= WEIGHT_W'(4);
      burst_cnt  <= '0;
      out_sel    <= 1'b1;
      hi_pkt_cnt <= '0;
      lo_pkt_cnt <= '0;
    end else begin
      state      <= state_nxt;
      burst_cnt  <= burst_nxt;
      weight     <= cfg_wen ? cfg_hi_weight : weight;
      out_sel    <= (state == IDLE && state_nxt != IDLE) ? (state_nxt == SEND_HI) : out_sel;
      hi_pkt_cnt <= hi_pkt_cnt + CNT_W'(hi_rd_en && hi_eop);
      lo_pkt_cnt <= lo_pkt_cnt + CNT_W'(lo_rd_en && lo_eop);
    end
  end
endmodule
